// File: rtl/sorter_pkg.sv
// Shared types for the bitonic sorter and its streaming front-end controller.
// Holds the sorter control word, the controller FSM states and the pad-value helper.
package sorter_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    LAUNCH = 1'b1
  } tsc_state_e;

  typedef struct packed {
    logic [0:0] channel_16;
  } channel_t;

  typedef struct packed {
    logic     sign_ctrl;
    channel_t channel;
  } ctrl_t;

  // Pad element that sorts to the tail: zero for largest-first, all-ones for smallest-first.
  function automatic logic [63:0] pad_word(input logic dir, input int unsigned width);
    pad_word = dir ? 64'd0 : (64'hFFFF_FFFF_FFFF_FFFF >> (64 - width));
  endfunction

endpackage

// File: rtl/topk_sort_ctrl_out_fifo.sv
// Top-K result FIFO for topk_sort_ctrl; head-of-queue data is always visible on o_data.
module topk_out_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_valid
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    w_count_nxt = r_count;
    if (i_push && !i_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!i_push && i_pop) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ptr_inc(r_wr);
      end
      if (i_pop) r_rd <= ptr_inc(r_rd);
      r_count <= w_count_nxt;
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_valid = (r_count != '0);

endmodule

// File: rtl/topk_sort_ctrl.sv
// Streaming front-end for the 16-input bitonic sorter: frames, pads, credit-gated launch, top-K capture.
// Optional latency checker enabled by defining TOPK_SORT_CTRL_LAT_CHECK_EN.
module topk_sort_ctrl
  import sorter_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned DATALENGTH = 16,
  parameter int unsigned K          = 4,
  parameter int unsigned SORT_LAT   = 4,
  parameter int unsigned OUT_DEPTH  = 4
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [DATAWIDTH-1:0]              in_data_i,
  input  logic                              in_last_i,
  input  logic                              dir_i,
  output ctrl_t                             sort_ctrl_o,
  output logic [DATAWIDTH*DATALENGTH-1:0]   sort_x_o,
  input  ctrl_t                             sort_ctrl_i,
  input  logic [DATAWIDTH*DATALENGTH-1:0]   sort_y_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [DATAWIDTH*K-1:0]            out_data_o,
  output logic                              err_o
);

  localparam int unsigned IDX_W = $clog2(DATALENGTH + 1);
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned OUT_W = DATAWIDTH * K;

  tsc_state_e           r_state;
  tsc_state_e           w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATAWIDTH-1:0] r_buf [DATALENGTH];
  logic                 r_frame_dir;
  logic                 r_launch;
  logic                 r_sign;
  logic                 r_in_ready;
  logic [CNT_W-1:0]     r_inflight;
  logic [CNT_W-1:0]     w_inflight_nxt;
  logic [CNT_W-1:0]     w_fifo_cnt;
  logic [CNT_W-1:0]     w_fifo_cnt_nxt;
  logic                 w_accept;
  logic                 w_freeze;
  logic                 w_dir;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_out_valid;
  logic                 w_launch_nxt;
  logic                 w_unused;

  assign w_accept = in_valid_i & r_in_ready;
  assign w_freeze = w_accept & ((r_idx == IDX_W'(DATALENGTH - 1)) | in_last_i);
  assign w_dir    = (r_idx == '0) ? dir_i : r_frame_dir;
  // Returns with nothing in flight are stale (e.g. launched before a reset) and are dropped.
  assign w_push   = sort_ctrl_i.channel.channel_16[0] & (r_inflight != '0);
  assign w_pop    = w_out_valid & out_ready_i;
  assign w_unused = ^{sort_ctrl_i.sign_ctrl, sort_y_i};

  always_comb begin
    w_state_nxt    = r_state;
    w_inflight_nxt = r_inflight;
    w_fifo_cnt_nxt = w_fifo_cnt;
    w_launch_nxt   = 1'b0;
    case (r_state)
      FILL:    if (w_freeze) w_state_nxt = LAUNCH;
      LAUNCH:  if (r_launch) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
    if (r_launch && !w_push)      w_inflight_nxt = r_inflight + CNT_W'(1);
    else if (!r_launch && w_push) w_inflight_nxt = r_inflight - CNT_W'(1);
    if (w_push && !w_pop)         w_fifo_cnt_nxt = w_fifo_cnt + CNT_W'(1);
    else if (!w_push && w_pop)    w_fifo_cnt_nxt = w_fifo_cnt - CNT_W'(1);
    // Pulse is registered, so grant it from next-cycle occupancy to reserve a FIFO slot.
    w_launch_nxt = (w_state_nxt == LAUNCH) &&
                   ((SUM_W'(w_fifo_cnt_nxt) + SUM_W'(w_inflight_nxt)) < SUM_W'(OUT_DEPTH));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= FILL;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_idx       <= '0;
      r_frame_dir <= 1'b0;
      r_launch    <= 1'b0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_inflight  <= '0;
    end else begin
      r_launch   <= w_launch_nxt;
      r_in_ready <= (w_state_nxt == FILL);
      r_inflight <= w_inflight_nxt;
      if (w_launch_nxt) r_sign <= w_dir;
      if (w_accept && (r_idx == '0)) r_frame_dir <= dir_i;
      if (r_launch)      r_idx <= '0;
      else if (w_accept) r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Frame buffer; the closing beat also pads every slot above it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int j = 0; j < int'(DATALENGTH); j++) r_buf[j] <= '0;
    end else if (w_accept) begin
      for (int j = 0; j < int'(DATALENGTH); j++) begin
        if (IDX_W'(j) == r_idx)
          r_buf[j] <= in_data_i;
        else if (w_freeze && (IDX_W'(j) > r_idx))
          r_buf[j] <= DATAWIDTH'(pad_word(w_dir, DATAWIDTH));
      end
    end
  end

  for (genvar g = 0; g < int'(DATALENGTH); g++) begin : g_x
    assign sort_x_o[g*DATAWIDTH +: DATAWIDTH] = r_buf[g];
  end

  assign sort_ctrl_o = '{sign_ctrl: r_sign, channel: '{channel_16: r_launch}};
  assign in_ready_o  = r_in_ready;
  assign out_valid_o = w_out_valid;

  topk_out_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (sort_y_i[OUT_W-1:0]),
    .o_data  (out_data_o),
    .o_count (w_fifo_cnt),
    .o_valid (w_out_valid)
  );

`ifdef TOPK_SORT_CTRL_LAT_CHECK_EN
  logic [SORT_LAT:1] r_lat_sh;
  logic              r_err;

  // r_lat_sh[n] is high n cycles after a launch pulse; a return is due at age SORT_LAT.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_lat_sh <= '0;
      r_err    <= 1'b0;
    end else begin
      r_lat_sh[1] <= r_launch;
      for (int i = 2; i <= int'(SORT_LAT); i++) r_lat_sh[i] <= r_lat_sh[i-1];
      if (sort_ctrl_i.channel.channel_16[0] != r_lat_sh[SORT_LAT]) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_topk_sort_ctrl.sv
// Self-checking bench for topk_sort_ctrl with a behavioural sorter and a top-K reference model.
module tb_topk_sort_ctrl;
  import sorter_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned DL = 16;
  localparam int unsigned KK = 4;
  localparam int unsigned SL = 4;
  localparam int unsigned OD = 4;
  localparam int unsigned FW = DW * DL;
  localparam int unsigned OW = DW * KK;

  logic          clk;
  logic          rstn;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          in_last_i;
  logic          dir_i;
  ctrl_t         sort_ctrl_o;
  logic [FW-1:0] sort_x_o;
  ctrl_t         sort_ctrl_i;
  logic [FW-1:0] sort_y_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [OW-1:0] out_data_o;
  logic          err_o;

  topk_sort_ctrl #(
    .DATAWIDTH (DW), .DATALENGTH (DL), .K (KK), .SORT_LAT (SL), .OUT_DEPTH (OD)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .dir_i       (dir_i),
    .sort_ctrl_o (sort_ctrl_o),
    .sort_x_o    (sort_x_o),
    .sort_ctrl_i (sort_ctrl_i),
    .sort_y_i    (sort_y_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: pad to a full frame, order by direction, keep the first K.
  function automatic logic [FW-1:0] sort_frame(input logic [FW-1:0] x, input logic dir);
    logic [DW-1:0] q[$];
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DL); i++) q.push_back(x[i*DW +: DW]);
    if (dir) q.rsort();
    else     q.sort();
    for (int i = 0; i < int'(DL); i++) r[i*DW +: DW] = q[i];
    return r;
  endfunction

  function automatic logic [FW-1:0] pad_frame(input logic [FW-1:0] d, input int n, input logic dir);
    logic [FW-1:0] r;
    for (int i = 0; i < int'(DL); i++)
      r[i*DW +: DW] = (i < n) ? d[i*DW +: DW] : (dir ? {DW{1'b0}} : {DW{1'b1}});
    return r;
  endfunction

  function automatic logic [OW-1:0] ref_topk(input logic [FW-1:0] d, input int n, input logic dir);
    logic [FW-1:0] s;
    s = sort_frame(pad_frame(d, n, dir), dir);
    return s[OW-1:0];
  endfunction

  // Behavioural sorter: fixed latency SL, optionally one cycle late; inject forces a stray return.
  logic          pipe_v [0:SL];
  logic [FW-1:0] pipe_y [0:SL];
  logic          lat_extra;
  logic          inject;

  initial begin
    for (int i = 0; i <= int'(SL); i++) begin
      pipe_v[i] = 1'b0;
      pipe_y[i] = '0;
    end
  end

  always @(posedge clk) begin
    pipe_v[0] <= sort_ctrl_o.channel.channel_16[0];
    pipe_y[0] <= sort_frame(sort_x_o, sort_ctrl_o.sign_ctrl);
    for (int i = 1; i <= int'(SL); i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_y[i] <= pipe_y[i-1];
    end
  end

  always_comb begin
    sort_ctrl_i = '0;
    sort_ctrl_i.channel.channel_16[0] = (lat_extra ? pipe_v[SL] : pipe_v[SL-1]) | inject;
    sort_y_i = lat_extra ? pipe_y[SL] : pipe_y[SL-1];
  end

  int launches = 0;
  always @(posedge clk) if (sort_ctrl_o.channel.channel_16[0]) launches++;

  // Output side: drives out_ready_i per rdy_mode and scores each accepted result in order.
  int            rdy_mode;
  int            rx_cnt = 0;
  logic [OW-1:0] exp_q[$];
  logic          hold_v = 1'b0;
  logic [OW-1:0] hold_d;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = 1'($urandom_range(0, 1));
      3:       begin out_ready_i = 1'b1; rdy_mode = 2; end
      default: out_ready_i = 1'b0;
    endcase
    if (rstn && hold_v && out_valid_o) chk("out_hold", FW'(out_data_o), FW'(hold_d));
    hold_v = 1'b0;
    if (rstn && out_valid_o) begin
      if (out_ready_i) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got %h expected no result", out_data_o);
        end else begin
          chk("out_data", FW'(out_data_o), FW'(exp_q.pop_front()));
        end
      end else begin
        hold_v = 1'b1;
        hold_d = out_data_o;
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic dir);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    dir_i      = dir;
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: got in_ready_o=0 for %0d cycles expected 1", n);
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  // Non-first beats carry a random dir so only the first beat's dir may matter.
  task automatic send_frame(input logic [FW-1:0] d, input int n, input logic dir, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
      send_beat(d[i*DW +: DW], (i == n - 1) && (n < int'(DL)), (i == 0) ? dir : 1'($urandom));
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, FW'(exp_q.size()), FW'(0));
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", FW'(in_ready_o), FW'(1));
    chk("rst_out_valid", FW'(out_valid_o), FW'(0));
    chk("rst_out_data", FW'(out_data_o), FW'(0));
    chk("rst_sort_ctrl", FW'(sort_ctrl_o), FW'(0));
    chk("rst_sort_x", sort_x_o, FW'(0));
    chk("rst_err", FW'(err_o), FW'(0));
  endtask

  typedef struct packed {
    logic [4:0]    n;
    logic          dir;
    logic [FW-1:0] data;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t          tbl [4];
  logic [FW-1:0] d;
  logic          dr;
  int            nb;
  int            base;
  logic          exp_err;

  initial begin
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_last_i  = 1'b0;
    dir_i      = 1'b0;
    rdy_mode   = 0;
    lat_extra  = 1'b0;
    inject     = 1'b0;
    rstn       = 1'b0;
`ifdef TOPK_SORT_CTRL_LAT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    d = '0;
    for (int i = 0; i < int'(DL); i++) d[i*DW +: DW] = DW'(i + 1);
    tbl[0] = '{n: 5'd16, dir: 1'b1, data: d, exp: 32'h0D0E0F10};
    tbl[1] = '{n: 5'd3, dir: 1'b0, data: FW'({8'd9, 8'd3, 8'd7}), exp: 32'hFF090703};
    tbl[2] = '{n: 5'd1, dir: 1'b1, data: FW'(8'd42), exp: 32'h0000002A};
    tbl[3] = '{n: 5'd5, dir: 1'b1, data: FW'({8'd1, 8'd99, 8'd17, 8'd200, 8'd5}), exp: 32'h051163C8};

    repeat (3) @(negedge clk);
    chk_reset_vals();
    rstn = 1'b1;
    @(negedge clk);

    // Directed frames: full, short, single-beat, short descending.
    for (int t = 0; t < 4; t++) begin
      exp_q.push_back(tbl[t].exp);
      send_frame(tbl[t].data, int'(tbl[t].n), tbl[t].dir, 1'b0);
      chk("launch_pulse", FW'(sort_ctrl_o.channel.channel_16[0]), FW'(1));
      chk("launch_sign", FW'(sort_ctrl_o.sign_ctrl), FW'(tbl[t].dir));
      chk("launch_frame", sort_x_o, pad_frame(tbl[t].data, int'(tbl[t].n), tbl[t].dir));
      chk("launch_stall", FW'(in_ready_o), FW'(0));
      wait_drain("table_drain");
    end

    // Backpressure: five frames against a stalled output, only OD may launch.
    rdy_mode = 2;
    base = launches;
    for (int f = 0; f < 5; f++) begin
      d  = {$urandom(), $urandom(), $urandom(), $urandom()};
      dr = 1'($urandom);
      exp_q.push_back(ref_topk(d, int'(DL), dr));
      send_frame(d, int'(DL), dr, 1'b0);
    end
    repeat (20) @(negedge clk);
    chk("bp_launches", FW'(launches - base), FW'(OD));
    chk("bp_stall", FW'(in_ready_o), FW'(0));
    chk("bp_no_pulse", FW'(sort_ctrl_o.channel.channel_16[0]), FW'(0));
    @(posedge clk);
    rdy_mode = 3;
    @(negedge clk);
    @(negedge clk);
    chk("bp_relaunch", FW'(sort_ctrl_o.channel.channel_16[0]), FW'(1));
    rdy_mode = 0;
    wait_drain("bp_drain");
    chk("bp_total", FW'(launches - base), FW'(5));

    // Random frames with random output stalls so launches, captures, pushes and pops collide.
    rdy_mode = 1;
    base = rx_cnt;
    for (int f = 0; f < 20; f++) begin
      d  = {$urandom(), $urandom(), $urandom(), $urandom()};
      nb = $urandom_range(1, DL);
      dr = 1'($urandom);
      exp_q.push_back(ref_topk(d, nb, dr));
      send_frame(d, nb, dr, 1'b1);
    end
    wait_drain("rand_drain");
    chk("rand_count", FW'(rx_cnt - base), FW'(20));
    rdy_mode = 0;
    chk("err_clean", FW'(err_o), FW'(0));

    // Reset after half a frame, then a clean full frame.
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) send_beat(DW'(100 + i), 1'b0, 1'b1);
    rstn = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_q.push_back(ref_topk(d, int'(DL), 1'b0));
    send_frame(d, int'(DL), 1'b0, 1'b0);
    chk("rst_relaunch", FW'(sort_ctrl_o.channel.channel_16[0]), FW'(1));
    chk("rst_frame", sort_x_o, d);
    wait_drain("rst_drain");

    // Sorter returns one cycle late.
    repeat (10) @(negedge clk);
    lat_extra = 1'b1;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_q.push_back(ref_topk(d, 7, 1'b1));
    send_frame(d, 7, 1'b1, 1'b0);
    wait_drain("late_drain");
    chk("late_err", FW'(err_o), FW'(exp_err));
    repeat (5) @(negedge clk);
    chk("late_err_sticky", FW'(err_o), FW'(exp_err));
    lat_extra = 1'b0;

    // Stray return with nothing in flight is dropped.
    repeat (10) @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_dropped", FW'(out_valid_o), FW'(0));
    chk("stray_err", FW'(err_o), FW'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
